// File: rtl/scoreboard_pkg.sv
// Shared glyphs, digit codes and conversion FSM states for the scoreboard display.
package scoreboard_pkg;

    localparam logic [6:0] GLYPH_0     = 7'b1000000;
    localparam logic [6:0] GLYPH_1     = 7'b1111001;
    localparam logic [6:0] GLYPH_2     = 7'b0100100;
    localparam logic [6:0] GLYPH_3     = 7'b0110000;
    localparam logic [6:0] GLYPH_4     = 7'b0011001;
    localparam logic [6:0] GLYPH_5     = 7'b0010010;
    localparam logic [6:0] GLYPH_6     = 7'b0000010;
    localparam logic [6:0] GLYPH_7     = 7'b1111000;
    localparam logic [6:0] GLYPH_8     = 7'b0000000;
    localparam logic [6:0] GLYPH_9     = 7'b0010000;
    localparam logic [6:0] GLYPH_BLANK = 7'b1111111;
    localparam logic [6:0] GLYPH_DASH  = 7'b0111111;
    localparam logic [6:0] GLYPH_P     = 7'b0001100;

    localparam logic [3:0] CODE_BLANK = 4'hA;
    localparam logic [3:0] CODE_DASH  = 4'hB;
    localparam logic [3:0] CODE_P     = 4'hC;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SHIFT,
        ST_COMMIT
    } conv_state_t;

    function automatic logic [6:0] code_to_glyph(input logic [3:0] code);
        case (code)
            4'd0:       return GLYPH_0;
            4'd1:       return GLYPH_1;
            4'd2:       return GLYPH_2;
            4'd3:       return GLYPH_3;
            4'd4:       return GLYPH_4;
            4'd5:       return GLYPH_5;
            4'd6:       return GLYPH_6;
            4'd7:       return GLYPH_7;
            4'd8:       return GLYPH_8;
            4'd9:       return GLYPH_9;
            CODE_DASH:  return GLYPH_DASH;
            CODE_P:     return GLYPH_P;
            default:    return GLYPH_BLANK;
        endcase
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble: 8-bit binary to 3-digit BCD, one bit per cycle.
module bin2bcd_seq
    import scoreboard_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  bin,
    output logic [11:0] bcd,
    output logic        done,
    output logic        idle
);

    conv_state_t state_q, state_d;
    logic [7:0]  bin_lat;
    logic [7:0]  bin_sh;
    logic [11:0] acc;
    logic [2:0]  bit_cnt;
    logic        load_en;
    logic        shift_en;

    function automatic logic [11:0] add3(input logic [11:0] v);
        logic [11:0] r;
        for (int i = 0; i < 3; i++) begin
            r[i*4 +: 4] = (v[i*4 +: 4] >= 4'd5) ? v[i*4 +: 4] + 4'd3 : v[i*4 +: 4];
        end
        return r;
    endfunction

    // Kept outside the next-state process so start may depend on idle without a comb loop.
    assign idle = (state_q == ST_IDLE);
    assign done = (state_q == ST_COMMIT);
    assign bcd  = acc;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            bit_cnt <= '0;
        end else begin
            state_q <= state_d;
            if (load_en)
                bit_cnt <= '0;
            else if (shift_en)
                bit_cnt <= bit_cnt + 3'd1;
        end
    end

    always_comb begin
        state_d  = state_q;
        load_en  = 1'b0;
        shift_en = 1'b0;
        case (state_q)
            ST_IDLE:   if (start) state_d = ST_LOAD;
            ST_LOAD: begin
                load_en = 1'b1;
                state_d = ST_SHIFT;
            end
            ST_SHIFT: begin
                shift_en = 1'b1;
                if (bit_cnt == 3'd7) state_d = ST_COMMIT;
            end
            ST_COMMIT: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (idle && start)
            bin_lat <= bin;
        if (load_en) begin
            bin_sh <= bin_lat;
            acc    <= '0;
        end else if (shift_en) begin
            {acc, bin_sh} <= {add3(acc), bin_sh} << 1;
        end
    end

endmodule

// File: rtl/scoreboard_display.sv
// Four-digit multiplexed seven-segment driver for runs/wickets with end-of-innings
// blink and end-of-game winner display.
module scoreboard_display
    import scoreboard_pkg::*;
#(
    parameter int SCAN_DIV  = 100000,
    parameter int BLINK_DIV = 25000000
) (
    input  logic       clk_fpga,
    input  logic       reset,
    input  logic [7:0] binaryRuns,
    input  logic [3:0] binaryWickets,
    input  logic       inningOver,
    input  logic       gameOver,
    input  logic       winner,
    output logic [6:0] seg,
    output logic [3:0] an,
    output logic       dp
);

    localparam int SCAN_W  = (SCAN_DIV  > 1) ? $clog2(SCAN_DIV)  : 1;
    localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [SCAN_W-1:0]  SCAN_LAST  = SCAN_W'(SCAN_DIV - 1);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);

    logic [SCAN_W-1:0]  scan_cnt;
    logic [BLINK_W-1:0] blink_cnt;
    logic [1:0]         digit_idx_q;
    logic               phase_q;
    logic [7:0]         runs_snap;
    logic [11:0]        digits_q;
    logic [3:0]         wickets_q;
    logic               conv_start;
    logic               conv_done;
    logic               conv_idle;
    logic [11:0]        conv_bcd;
    logic [3:0]         code_p0;
    logic               dp_p0;
    logic [3:0]         hund;
    logic [3:0]         tens;
    logic [3:0]         units;

    // A change seen while busy is picked up by this compare once the engine is idle again.
    assign conv_start = conv_idle && (binaryRuns != runs_snap);

    bin2bcd_seq u_bin2bcd (
        .clk   (clk_fpga),
        .rst   (reset),
        .start (conv_start),
        .bin   (binaryRuns),
        .bcd   (conv_bcd),
        .done  (conv_done),
        .idle  (conv_idle)
    );

    assign hund  = digits_q[11:8];
    assign tens  = digits_q[7:4];
    assign units = digits_q[3:0];

    always_comb begin
        code_p0 = CODE_BLANK;
        dp_p0   = 1'b1;
        if (gameOver && phase_q) begin
            case (digit_idx_q)
                2'd1:    code_p0 = CODE_P;
                2'd0:    code_p0 = winner ? 4'd2 : 4'd1;
                default: code_p0 = CODE_BLANK;
            endcase
        end else if (inningOver && phase_q) begin
            code_p0 = CODE_BLANK;
        end else begin
            case (digit_idx_q)
                2'd3:    code_p0 = (hund == 4'd0) ? CODE_BLANK : hund;
                2'd2:    code_p0 = (hund == 4'd0 && tens == 4'd0) ? CODE_BLANK : tens;
                2'd1: begin
                    code_p0 = units;
                    dp_p0   = 1'b0;
                end
                default: code_p0 = (wickets_q > 4'd9) ? CODE_DASH : wickets_q;
            endcase
        end
    end

    // Output stage: seg/an/dp registered one cycle after digit index, mode and phase.
    always_ff @(posedge clk_fpga) begin
        if (reset) begin
            scan_cnt    <= '0;
            digit_idx_q <= '0;
            blink_cnt   <= '0;
            phase_q     <= 1'b0;
            runs_snap   <= '0;
            digits_q    <= '0;
            wickets_q   <= '0;
            seg         <= GLYPH_BLANK;
            an          <= 4'b1111;
            dp          <= 1'b1;
        end else begin
            if (scan_cnt == SCAN_LAST) begin
                scan_cnt    <= '0;
                digit_idx_q <= digit_idx_q + 2'd1;
            end else begin
                scan_cnt <= scan_cnt + SCAN_W'(1);
            end
            if (blink_cnt == BLINK_LAST) begin
                blink_cnt <= '0;
                phase_q   <= ~phase_q;
            end else begin
                blink_cnt <= blink_cnt + BLINK_W'(1);
            end
            if (conv_start)
                runs_snap <= binaryRuns;
            if (conv_done)
                digits_q <= conv_bcd;
            wickets_q <= binaryWickets;
            seg       <= code_to_glyph(code_p0);
            an        <= ~(4'b0001 << digit_idx_q);
            dp        <= dp_p0;
        end
    end

endmodule

// File: tb/tb_scoreboard_display.sv
// Self-checking bench for scoreboard_display: directed tables, corner sequences,
// and randomized traffic against an arithmetic reference model.
module tb_scoreboard_display;

    localparam int SCAN  = 4;
    localparam int BLINK = 16;
    localparam logic [6:0] G_BLANK = 7'b1111111;
    localparam logic [6:0] G_DASH  = 7'b0111111;
    localparam logic [6:0] G_P     = 7'b0001100;

    logic       clk_fpga = 1'b0;
    logic       reset;
    logic [7:0] binaryRuns;
    logic [3:0] binaryWickets;
    logic       inningOver;
    logic       gameOver;
    logic       winner;
    logic [6:0] seg;
    logic [3:0] an;
    logic       dp;

    always #5 clk_fpga = ~clk_fpga;

    scoreboard_display #(.SCAN_DIV(SCAN), .BLINK_DIV(BLINK)) dut (
        .clk_fpga      (clk_fpga),
        .reset         (reset),
        .binaryRuns    (binaryRuns),
        .binaryWickets (binaryWickets),
        .inningOver    (inningOver),
        .gameOver      (gameOver),
        .winner        (winner),
        .seg           (seg),
        .an            (an),
        .dp            (dp)
    );

    int checks = 0;
    int errors = 0;

    function automatic logic [6:0] ref_glyph(input int d);
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Wait (bounded) for digit slot k, then check its glyph and decimal point.
    task automatic check_slot(input int k, input logic [6:0] es, input string name);
        int n;
        logic [3:0] tgt;
        n = 0;
        tgt = ~(4'b0001 << k);
        while (an !== tgt && n < 24) begin
            @(negedge clk_fpga);
            n++;
        end
        if (an !== tgt) begin
            checks++;
            errors++;
            $display("FAIL %s_slot actual an=%b required an=%b", name, an, tgt);
        end else begin
            chk({name, "_seg"}, 16'(seg), 16'(es));
            chk({name, "_dp"}, 16'(dp), (k == 1) ? 16'd0 : 16'd1);
        end
    endtask

    // Reference model: slot and phase come straight from the cycle count since reset;
    // a conversion started while idle becomes visible ten edges later.
    int         m_t, m_timer, m_disp, m_snap, m_wk;
    logic [6:0] m_seg;
    logic [3:0] m_an;
    logic       m_dp;
    bit         model_on = 1'b0;

    always @(posedge clk_fpga) begin : ref_model
        int slot, ph, h, tn, u;
        if (reset) begin
            m_seg = G_BLANK; m_an = 4'b1111; m_dp = 1'b1;
            m_t = 0; m_timer = 0; m_disp = 0; m_snap = 0; m_wk = 0;
        end else begin
            slot = (m_t / SCAN) % 4;
            ph   = (m_t / BLINK) % 2;
            h    = m_disp / 100;
            tn   = (m_disp / 10) % 10;
            u    = m_disp % 10;
            m_an = ~(4'b0001 << slot);
            m_dp = 1'b1;
            if (gameOver && ph == 1) begin
                if (slot == 1)      m_seg = G_P;
                else if (slot == 0) m_seg = ref_glyph(winner ? 2 : 1);
                else                m_seg = G_BLANK;
            end else if (inningOver && ph == 1) begin
                m_seg = G_BLANK;
            end else begin
                case (slot)
                    3: m_seg = (h == 0) ? G_BLANK : ref_glyph(h);
                    2: m_seg = (h == 0 && tn == 0) ? G_BLANK : ref_glyph(tn);
                    1: begin m_seg = ref_glyph(u); m_dp = 1'b0; end
                    default: m_seg = (m_wk > 9) ? G_DASH : ref_glyph(m_wk);
                endcase
            end
            m_t++;
            if (m_timer == 0) begin
                if (int'(binaryRuns) != m_snap) begin
                    m_snap  = int'(binaryRuns);
                    m_timer = 10;
                end
            end else begin
                m_timer--;
                if (m_timer == 0) m_disp = m_snap;
            end
            m_wk = int'(binaryWickets);
        end
    end

    typedef struct {
        logic [7:0] runs;
        logic [3:0] wk;
        logic [6:0] g3, g2, g1, g0;
    } vec_t;

    vec_t vecs [8];

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "simulation timeout");
    end

    initial begin
        int cnt, run, maxr, bad, c1, c2;
        bit saw, ok;

        reset = 1'b1; binaryRuns = 8'd0; binaryWickets = 4'd0;
        inningOver = 1'b0; gameOver = 1'b0; winner = 1'b0;

        vecs[0] = '{8'd137, 4'd3,  7'b1111001, 7'b0110000, 7'b1111000, 7'b0110000};
        vecs[1] = '{8'd0,   4'd0,  G_BLANK,    G_BLANK,    7'b1000000, 7'b1000000};
        vecs[2] = '{8'd5,   4'd9,  G_BLANK,    G_BLANK,    7'b0010010, 7'b0010000};
        vecs[3] = '{8'd40,  4'd10, G_BLANK,    7'b0011001, 7'b1000000, G_DASH};
        vecs[4] = '{8'd100, 4'd15, 7'b1111001, 7'b1000000, 7'b1000000, G_DASH};
        vecs[5] = '{8'd255, 4'd7,  7'b0100100, 7'b0010010, 7'b0010010, 7'b1111000};
        vecs[6] = '{8'd99,  4'd1,  G_BLANK,    7'b0010000, 7'b0010000, 7'b1111001};
        vecs[7] = '{8'd208, 4'd6,  7'b0100100, 7'b1000000, 7'b0000000, 7'b0000010};

        // Reset values, then first cycle after release.
        repeat (3) @(negedge clk_fpga);
        chk("rst_an",  16'(an),  16'hf);
        chk("rst_seg", 16'(seg), 16'(G_BLANK));
        chk("rst_dp",  16'(dp),  16'd1);
        reset = 1'b0;
        @(negedge clk_fpga);
        chk("first_an",  16'(an),  16'(4'b1110));
        chk("first_seg", 16'(seg), 16'(7'b1000000));
        chk("first_dp",  16'(dp),  16'd1);
        check_slot(1, 7'b1000000, "rst_units");
        check_slot(2, G_BLANK, "rst_tens");
        check_slot(3, G_BLANK, "rst_hund");

        // Input change mid-SHIFT: 255 must still appear, then 5 takes over.
        binaryRuns = 8'd255;
        repeat (4) @(negedge clk_fpga);
        binaryRuns = 8'd5;
        repeat (9) @(negedge clk_fpga);
        saw = 1'b0;
        for (int i = 0; i < 9; i++) begin
            if ((an == 4'b0111 && seg == 7'b0100100) || (an == 4'b1011 && seg == 7'b0010010))
                saw = 1'b1;
            @(negedge clk_fpga);
        end
        chk("mid_255_seen", 16'(saw), 16'd1);
        repeat (12) @(negedge clk_fpga);
        check_slot(3, G_BLANK, "final5_hund");
        check_slot(2, G_BLANK, "final5_tens");
        check_slot(1, 7'b0010010, "final5_units");
        check_slot(0, 7'b1000000, "final5_wk");

        // Table of static score patterns.
        foreach (vecs[i]) begin
            binaryRuns = vecs[i].runs;
            binaryWickets = vecs[i].wk;
            repeat (14) @(negedge clk_fpga);
            check_slot(3, vecs[i].g3, $sformatf("vec%0d_hund", i));
            check_slot(2, vecs[i].g2, $sformatf("vec%0d_tens", i));
            check_slot(1, vecs[i].g1, $sformatf("vec%0d_units", i));
            check_slot(0, vecs[i].g0, $sformatf("vec%0d_wk", i));
        end

        // End of innings blink with score 137/3.
        binaryRuns = 8'd137; binaryWickets = 4'd3;
        repeat (14) @(negedge clk_fpga);
        inningOver = 1'b1;
        repeat (2) @(negedge clk_fpga);
        cnt = 0; run = 0; maxr = 0; bad = 0;
        for (int i = 0; i < 64; i++) begin
            if (seg == G_BLANK && dp == 1'b1) begin
                cnt++; run++;
                if (run > maxr) maxr = run;
            end else begin
                run = 0;
            end
            if (!(an inside {4'b1110, 4'b1101, 4'b1011, 4'b0111})) bad++;
            @(negedge clk_fpga);
        end
        chk("inning_blank_cycles", 16'(cnt), 16'd32);
        chk("inning_blank_run", 16'(maxr), 16'd16);
        chk("inning_an_scan", 16'(bad), 16'd0);

        // End of game, team 2 wins: score alternates with blank/blank/P/2.
        gameOver = 1'b1; winner = 1'b1;
        repeat (2) @(negedge clk_fpga);
        c1 = 0; c2 = 0; bad = 0;
        for (int i = 0; i < 64; i++) begin
            case (an)
                4'b0111: ok = dp && (seg == 7'b1111001 || seg == G_BLANK);
                4'b1011: ok = dp && (seg == 7'b0110000 || seg == G_BLANK);
                4'b1101: ok = (seg == 7'b1111000 && !dp) || (seg == G_P && dp);
                4'b1110: ok = dp && (seg == 7'b0110000 || seg == 7'b0100100);
                default: ok = 1'b0;
            endcase
            if (!ok) bad++;
            if (an == 4'b1101 && seg == G_P && dp) c1++;
            if (an == 4'b1110 && seg == 7'b0100100) c2++;
            @(negedge clk_fpga);
        end
        chk("game_p_cycles", 16'(c1), 16'd8);
        chk("game_2_cycles", 16'(c2), 16'd8);
        chk("game_bad_cycles", 16'(bad), 16'd0);

        winner = 1'b0;
        repeat (2) @(negedge clk_fpga);
        c1 = 0;
        for (int i = 0; i < 32; i++) begin
            if (an == 4'b1110 && seg == 7'b1111001) c1++;
            @(negedge clk_fpga);
        end
        chk("game_1_cycles", 16'(c1), 16'd4);

        // Reset in the middle of a game phase.
        repeat (5) @(negedge clk_fpga);
        reset = 1'b1;
        @(negedge clk_fpga);
        chk("midrst_an",  16'(an),  16'hf);
        chk("midrst_seg", 16'(seg), 16'(G_BLANK));
        chk("midrst_dp",  16'(dp),  16'd1);
        reset = 1'b0; gameOver = 1'b0; inningOver = 1'b0;

        // Randomized traffic against the reference model.
        model_on = 1'b1;
        for (int i = 0; i < 1200; i++) begin
            @(negedge clk_fpga);
            chk("rand_out", 16'({an, seg, dp}), 16'({m_an, m_seg, m_dp}));
            reset = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 7) == 0)  binaryRuns    = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 9) == 0)  binaryWickets = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 59) == 0) inningOver    = ~inningOver;
            if ($urandom_range(0, 79) == 0) gameOver      = ~gameOver;
            if ($urandom_range(0, 39) == 0) winner        = ~winner;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
